change_dispense_ctrl: RTL
=========================

Name: change_dispense_ctrl

Overview:
- Sequential controller that pays out a change amount in cents, one coin at a time, through a single shared coin-ejector mechanism.
- Tracks the coin inventory and chooses coins greedily from largest to smallest, skipping any denomination that is empty.
- Reports how many of each coin were dispensed and any shortfall.
- Sits between the vending transaction FSM (start/change) and the ejector hardware (req/ack handshake).

Parameters:
- CHG_W, 9, width of change amount and remainder in cents.
- INV_W, 5, width of each inventory and dispensed counter (saturating max 2^INV_W-1).
- TIMEOUT_CYCLES, 255, ack watchdog limit (used only with the optional feature).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begin a payout; sampled only in IDLE.
- change  input  CHG_W  amount in cents; captured when start is accepted.
- busy  output  1  high in every state except IDLE.
- eject_req  output  1  request to eject one coin.
- eject_coin  output  2  coin code while eject_req is high: 01=quarter(25), 10=dime(10), 11=nickel(5), 00 otherwise.
- eject_ack  input  1  ejector done; a coin is counted only in a cycle where eject_req&&eject_ack.
- done  output  1  one-cycle pulse at the end of every payout, success or short.
- short  output  1  level signal; set with done when the payout could not complete; cleared on the next accepted start.
- remainder  output  CHG_W  undispensed cents, valid when done is high; held until the next start.
- quarters, dimes, nickels  output  INV_W each  coins dispensed in the current or last payout.
- restock_valid  input  1  add coins to the inventory.
- restock_sel  input  2  coin code, same encoding as eject_coin; code 00 is ignored.
- restock_cnt  input  INV_W  number of coins to add.
- inv_q, inv_d, inv_n  output  INV_W each  current inventory.

Behaviour:
- Reset (asynchronous): state=IDLE. All outputs, inventories, counters and remainder are 0. eject_req drops immediately, including in the middle of a payout; the in-flight coin is not counted.
- States:
  - IDLE: if start, then rem<=change, clear quarters/dimes/nickels, clear short, go to SELECT.
  - SELECT: pick the coin for this cycle in priority order, quarter (rem>=25 and inv_q>0), then dime (rem>=10 and inv_d>0), then nickel (rem>=5 and inv_n>0).
    - If rem==0, go to DONE.
    - If a coin is picked, latch it and go to EJECT.
    - If no coin fits, go to FAIL.
  - EJECT: eject_req=1 and eject_coin held stable until ack.
    - On the ack cycle: rem-=value, the matching inventory decrements, the matching dispensed counter increments, and the state returns to SELECT.
    - eject_req is low in the cycle after ack.
  - DONE: done=1 for one cycle, remainder=0, then IDLE.
  - FAIL: done=1 and short=1 for one cycle, remainder=rem, then IDLE. short stays high after leaving FAIL.
- Latency:
  - change=0 gives done 2 cycles after the start edge.
  - Each coin costs 1 SELECT cycle plus the EJECT cycles (at least 1).
- Amounts that are not a multiple of 5 end in FAIL with remainder = change mod 5 (or more if inventory runs short).
- start while busy is ignored. eject_ack outside EJECT is ignored.
- Restock is accepted in any state: inv += restock_cnt, saturating at max.
  - If it coincides with an ack decrement of the same coin, the result is inv+cnt-1, saturated.
- Dispensed counters saturate at max.
- The greedy choice re-evaluates the inventory every SELECT cycle, so a restock during a payout can be used immediately.

Optional Feature:
- Macro: DISPENSE_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while in EJECT. If TIMEOUT_CYCLES elapse without ack, eject_req drops, the coin is not counted, and the block goes to FAIL with the current rem.
  - Adds output ack_timeout (1 bit), set with that FAIL and cleared on the next start.
- Without the macro: EJECT waits indefinitely, there is no counter, and the ack_timeout port is absent.

Decomposition:
- Shared package change_pkg:
  - coin code typedef (NONE/QUARTER/DIME/NICKEL).
  - value constants 25/10/5.
  - state enum.
  - function mapping coin code to value.
- Sub-module coin_inventory: three saturating counters with restock, decrement and precedence rules. It is instantiated once and the controller reads its counts.

Test Plan:
- Inventory Q=D=N=10; start with change=65 -> ejects Q,Q,D,N in that order; done; quarters=2, dimes=1, nickels=1, short=0, inv_q=8.
- Inventory Q=0, D=10, N=10; change=30 -> ejects D,D,D; done; short=0.
- Inventory Q=1, D=0, N=1; change=40 -> ejects Q then N; FAIL; short=1, remainder=10.
- change=0 -> done exactly 2 cycles after start, with no eject_req.
- change=27 with full inventory -> Q; FAIL; remainder=2.
- Assert rst during EJECT with ack withheld -> eject_req drops asynchronously; all counters read 0 afterwards.
- Restock Q by 31 when inv_q=30, coinciding with a Q ack -> inv_q=31 (saturated).

Source files
------------

// File: rtl/change_dispense_ctrl_pkg.sv
// Shared types for the change dispenser: coin codes, coin values and controller states.
package change_pkg;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'b00,
        COIN_QUARTER = 2'b01,
        COIN_DIME    = 2'b10,
        COIN_NICKEL  = 2'b11
    } coin_e;

    localparam logic [4:0] VAL_QUARTER = 5'd25;
    localparam logic [4:0] VAL_DIME    = 5'd10;
    localparam logic [4:0] VAL_NICKEL  = 5'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_EJECT  = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAIL   = 3'd4
    } state_e;

    function automatic logic [4:0] coin_value(input coin_e c);
        case (c)
            COIN_QUARTER: return VAL_QUARTER;
            COIN_DIME:    return VAL_DIME;
            COIN_NICKEL:  return VAL_NICKEL;
            default:      return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// Bundle of payout, ejector, restock and status signals; ack_timeout exists only with DISPENSE_TIMEOUT_EN.
interface change_dispense_ctrl_if #(
    parameter int CHG_W = 9,
    parameter int INV_W = 5
);
    logic             start;
    logic [CHG_W-1:0] change;
    logic             busy;
    logic             eject_req;
    logic [1:0]       eject_coin;
    logic             eject_ack;
    logic             done;
    logic             short;
    logic [CHG_W-1:0] remainder;
    logic [INV_W-1:0] quarters;
    logic [INV_W-1:0] dimes;
    logic [INV_W-1:0] nickels;
    logic             restock_valid;
    logic [1:0]       restock_sel;
    logic [INV_W-1:0] restock_cnt;
    logic [INV_W-1:0] inv_q;
    logic [INV_W-1:0] inv_d;
    logic [INV_W-1:0] inv_n;
`ifdef DISPENSE_TIMEOUT_EN
    logic             ack_timeout;
`endif

    modport master (
`ifdef DISPENSE_TIMEOUT_EN
        input  ack_timeout,
`endif
        output start, change, eject_ack, restock_valid, restock_sel, restock_cnt,
        input  busy, eject_req, eject_coin, done, short, remainder,
        input  quarters, dimes, nickels, inv_q, inv_d, inv_n
    );

    modport slave (
`ifdef DISPENSE_TIMEOUT_EN
        output ack_timeout,
`endif
        input  start, change, eject_ack, restock_valid, restock_sel, restock_cnt,
        output busy, eject_req, eject_coin, done, short, remainder,
        output quarters, dimes, nickels, inv_q, inv_d, inv_n
    );

endinterface

// File: rtl/change_dispense_ctrl_inventory.sv
// Coin inventory: three saturating counters; restock and an ejected coin in the same cycle net to inv+cnt-1.
module coin_inventory
    import change_pkg::*;
#(
    parameter int INV_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restock_valid,
    input  coin_e            restock_sel,
    input  logic [INV_W-1:0] restock_cnt,
    input  logic             dec_valid,
    input  coin_e            dec_sel,
    output logic [INV_W-1:0] inv_q,
    output logic [INV_W-1:0] inv_d,
    output logic [INV_W-1:0] inv_n
);

    localparam logic [INV_W:0] MAX = {1'b0, {INV_W{1'b1}}};

    // Add first, then decrement, then saturate: restock overflow never eats the decrement.
    function automatic logic [INV_W-1:0] next_cnt(input logic [INV_W-1:0] cur,
                                                  input logic add_en,
                                                  input logic dec_en,
                                                  input logic [INV_W-1:0] add);
        logic [INV_W:0] sum;
        sum = {1'b0, cur} + (add_en ? {1'b0, add} : '0);
        if (dec_en && sum != '0)
            sum = sum - {{INV_W{1'b0}}, 1'b1};
        return (sum > MAX) ? MAX[INV_W-1:0] : sum[INV_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q <= '0;
            inv_d <= '0;
            inv_n <= '0;
        end else begin
            inv_q <= next_cnt(inv_q, restock_valid && restock_sel == COIN_QUARTER,
                              dec_valid && dec_sel == COIN_QUARTER, restock_cnt);
            inv_d <= next_cnt(inv_d, restock_valid && restock_sel == COIN_DIME,
                              dec_valid && dec_sel == COIN_DIME, restock_cnt);
            inv_n <= next_cnt(inv_n, restock_valid && restock_sel == COIN_NICKEL,
                              dec_valid && dec_sel == COIN_NICKEL, restock_cnt);
        end
    end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Greedy change payout controller: IDLE wait | SELECT pick coin | EJECT handshake | DONE paid | FAIL short.
// Optional ejector ack watchdog enabled by DISPENSE_TIMEOUT_EN.
module change_dispense_ctrl
    import change_pkg::*;
#(
    parameter int CHG_W = 9,
    parameter int INV_W = 5
`ifdef DISPENSE_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input logic                 clk,
    input logic                 rst,
    change_dispense_ctrl_if.slave bus
);

    localparam logic [INV_W-1:0] CNT_MAX = '1;

    state_e           state, state_nxt;
    coin_e            coin_sel, pick;
    logic [CHG_W-1:0] rem, remainder_r;
    logic [INV_W-1:0] quarters_r, dimes_r, nickels_r;
    logic [INV_W-1:0] inv_q, inv_d, inv_n;
    logic             short_r, ack_fire;

`ifdef DISPENSE_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer;
    logic             ack_timeout_r;
`endif

    function automatic logic [INV_W-1:0] sat_inc(input logic [INV_W-1:0] x);
        return (x == CNT_MAX) ? x : x + INV_W'(1);
    endfunction

    assign ack_fire = (state == ST_EJECT) && bus.eject_ack;

    coin_inventory #(.INV_W(INV_W)) u_inv (
        .clk           (clk),
        .rst           (rst),
        .restock_valid (bus.restock_valid),
        .restock_sel   (coin_e'(bus.restock_sel)),
        .restock_cnt   (bus.restock_cnt),
        .dec_valid     (ack_fire),
        .dec_sel       (coin_sel),
        .inv_q         (inv_q),
        .inv_d         (inv_d),
        .inv_n         (inv_n)
    );

    always_comb begin
        pick      = COIN_NONE;
        state_nxt = state;
        if (rem >= CHG_W'(VAL_QUARTER) && inv_q != '0)
            pick = COIN_QUARTER;
        else if (rem >= CHG_W'(VAL_DIME) && inv_d != '0)
            pick = COIN_DIME;
        else if (rem >= CHG_W'(VAL_NICKEL) && inv_n != '0)
            pick = COIN_NICKEL;

        case (state)
            ST_IDLE:   if (bus.start) state_nxt = ST_SELECT;
            ST_SELECT: begin
                if (rem == '0)              state_nxt = ST_DONE;
                else if (pick != COIN_NONE) state_nxt = ST_EJECT;
                else                        state_nxt = ST_FAIL;
            end
            ST_EJECT: begin
                if (bus.eject_ack)          state_nxt = ST_SELECT;
`ifdef DISPENSE_TIMEOUT_EN
                else if (timer == '0)       state_nxt = ST_FAIL;
`endif
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            coin_sel    <= COIN_NONE;
            rem         <= '0;
            remainder_r <= '0;
            quarters_r  <= '0;
            dimes_r     <= '0;
            nickels_r   <= '0;
            short_r     <= 1'b0;
`ifdef DISPENSE_TIMEOUT_EN
            timer         <= '0;
            ack_timeout_r <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && bus.start) begin
                rem        <= bus.change;
                quarters_r <= '0;
                dimes_r    <= '0;
                nickels_r  <= '0;
                short_r    <= 1'b0;
`ifdef DISPENSE_TIMEOUT_EN
                ack_timeout_r <= 1'b0;
`endif
            end
            if (state == ST_SELECT) begin
                coin_sel <= pick;
`ifdef DISPENSE_TIMEOUT_EN
                timer    <= TMR_W'(TIMEOUT_CYCLES - 1);
`endif
            end
            if (ack_fire) begin
                rem <= rem - CHG_W'(coin_value(coin_sel));
                case (coin_sel)
                    COIN_QUARTER: quarters_r <= sat_inc(quarters_r);
                    COIN_DIME:    dimes_r    <= sat_inc(dimes_r);
                    COIN_NICKEL:  nickels_r  <= sat_inc(nickels_r);
                    default:      ;
                endcase
            end
`ifdef DISPENSE_TIMEOUT_EN
            if (state == ST_EJECT && !bus.eject_ack) begin
                if (timer != '0) timer <= timer - TMR_W'(1);
                else             ack_timeout_r <= 1'b1;
            end
`endif
            // Result latched on entry so it is visible in the same cycle as done.
            if (state_nxt == ST_DONE)
                remainder_r <= '0;
            if (state_nxt == ST_FAIL) begin
                remainder_r <= rem;
                short_r     <= 1'b1;
            end
        end
    end

    assign bus.busy       = (state != ST_IDLE);
    assign bus.eject_req  = (state == ST_EJECT);
    assign bus.eject_coin = (state == ST_EJECT) ? coin_sel : COIN_NONE;
    assign bus.done       = (state == ST_DONE) || (state == ST_FAIL);
    assign bus.short      = short_r;
    assign bus.remainder  = remainder_r;
    assign bus.quarters   = quarters_r;
    assign bus.dimes      = dimes_r;
    assign bus.nickels    = nickels_r;
    assign bus.inv_q      = inv_q;
    assign bus.inv_d      = inv_d;
    assign bus.inv_n      = inv_n;
`ifdef DISPENSE_TIMEOUT_EN
    assign bus.ack_timeout = ack_timeout_r;
`endif

endmodule
